// File: rtl/alu_shift_pkg.sv
// Purpose : shared op-code constants and op decode helper for the pipelined barrel shifter.
// Latency : n/a (package only).
// Backpressure : n/a (package only).
//
// Op encoding: bit0 = direction (1 = right), bit1 = arithmetic fill (right shifts only),
// bit2 = rotate (bit1 ignored). 3'b010 decodes as a plain left shift.
package alu_shift_pkg;

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b011;
    localparam logic [2:0] OP_ROL = 3'b100;
    localparam logic [2:0] OP_ROR = 3'b101;

    typedef struct packed {
        logic right;   // 1 = shift/rotate towards LSB
        logic arith;   // sign fill; only ever set for SRA
        logic rotate;  // wrap shifted-out bits to the other end
    } op_flags_t;

    function automatic op_flags_t op_flags(input logic [2:0] op);
        op_flags_t f;
        f.right  = op[0];
        f.rotate = op[2];
        // Arithmetic fill is only meaningful for a non-rotating right shift.
        f.arith  = (op == OP_SRA);
        return f;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// Purpose : one logarithmic level of the barrel shifter (shift/rotate by 2^K) plus its pipeline register.
// Latency : 1 cycle.
// Backpressure : holds all contents while i_advance is low; i_flush clears only the valid bit.
//
// Ports: clk/reset (sync, active-high); i_advance, i_flush control; i_* is the incoming
// operation (valid, op, full shift amount, sign fill bit, data, tag); o_* is the registered
// copy after this level has been applied.
module shift_stage
    import alu_shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5,
    parameter int SHW   = 5,
    parameter int K     = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_advance,
    input  logic             i_flush,
    input  logic             i_vld,
    input  logic [2:0]       i_op,
    input  logic [SHW-1:0]   i_shamt,
    input  logic             i_sign,
    input  logic [WIDTH-1:0] i_data,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_vld,
    output logic [2:0]       o_op,
    output logic [SHW-1:0]   o_shamt,
    output logic             o_sign,
    output logic [WIDTH-1:0] o_data,
    output logic [TAG_W-1:0] o_tag
);

    localparam int AMT = 1 << K;

    op_flags_t        w_f;
    logic [WIDTH-1:0] w_data;

    logic             r_vld;
    logic [2:0]       r_op;
    logic [SHW-1:0]   r_shamt;
    logic             r_sign;
    logic [WIDTH-1:0] r_data;
    logic [TAG_W-1:0] r_tag;

    // i_sign is the original operand MSB already qualified by SRA, so it is the
    // correct fill at every level regardless of what earlier levels did to the MSB.
    always_comb begin
        w_f    = op_flags(i_op);
        w_data = i_data;
        if (i_shamt[K]) begin
            if (w_f.rotate) begin
                if (w_f.right) w_data = {i_data[AMT-1:0], i_data[WIDTH-1:AMT]};
                else           w_data = {i_data[WIDTH-AMT-1:0], i_data[WIDTH-1:WIDTH-AMT]};
            end else if (w_f.right) begin
                w_data = {{AMT{i_sign}}, i_data[WIDTH-1:AMT]};
            end else begin
                w_data = {i_data[WIDTH-AMT-1:0], {AMT{1'b0}}};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld   <= 1'b0;
            r_op    <= '0;
            r_shamt <= '0;
            r_sign  <= 1'b0;
            r_data  <= '0;
            r_tag   <= '0;
        end else begin
            if (i_advance) begin
                r_vld   <= i_vld & ~i_flush;
                r_op    <= i_op;
                r_shamt <= i_shamt;
                r_sign  <= i_sign;
                r_data  <= w_data;
                r_tag   <= i_tag;
            end else if (i_flush) begin
                r_vld   <= 1'b0;
            end
        end
    end

    assign o_vld   = r_vld;
    assign o_op    = r_op;
    assign o_shamt = r_shamt;
    assign o_sign  = r_sign;
    assign o_data  = r_data;
    assign o_tag   = r_tag;

endmodule

// File: rtl/alu_shift_pipe.sv
// Purpose : pipelined barrel shifter (SLL/SRL/SRA/ROL/ROR) with a tag carried alongside each op.
// Latency : SHW cycles from accept to out_valid, one op per cycle.
// Backpressure : whole pipe stalls (bubbles kept) while out_valid & !out_ready; in_ready = advance.
//
// Ports: clk, reset (sync, active-high), flush (sync, drops in-flight ops);
// in_valid/in_ready/in_op/in_shamt/in_data/in_tag input handshake;
// out_valid/out_ready/out_data/out_tag result handshake.
module alu_shift_pipe
    import alu_shift_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int TAG_W = 5,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [WIDTH-1:0] in_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
);

    op_flags_t        w_in_f;
    logic             w_advance;

    // Index k feeds stage k; index SHW is the last stage's register.
    logic             w_vld   [SHW+1];
    logic [2:0]       w_op    [SHW+1];
    logic [SHW-1:0]   w_shamt [SHW+1];
    logic             w_sign  [SHW+1];
    logic [WIDTH-1:0] w_data  [SHW+1];
    logic [TAG_W-1:0] w_tag   [SHW+1];

    logic             w_unused_tail;

    assign w_advance = ~out_valid | out_ready;
    assign in_ready  = w_advance;

    assign w_in_f     = op_flags(in_op);
    assign w_vld[0]   = in_valid;
    assign w_op[0]    = in_op;
    assign w_shamt[0] = in_shamt;
    // Capture the sign once at entry so every level fills with the original MSB.
    assign w_sign[0]  = w_in_f.arith & in_data[WIDTH-1];
    assign w_data[0]  = in_data;
    assign w_tag[0]   = in_tag;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        shift_stage #(
            .WIDTH (WIDTH),
            .TAG_W (TAG_W),
            .SHW   (SHW),
            .K     (k)
        ) u_stage (
            .clk       (clk),
            .reset     (reset),
            .i_advance (w_advance),
            .i_flush   (flush),
            .i_vld     (w_vld[k]),
            .i_op      (w_op[k]),
            .i_shamt   (w_shamt[k]),
            .i_sign    (w_sign[k]),
            .i_data    (w_data[k]),
            .i_tag     (w_tag[k]),
            .o_vld     (w_vld[k+1]),
            .o_op      (w_op[k+1]),
            .o_shamt   (w_shamt[k+1]),
            .o_sign    (w_sign[k+1]),
            .o_data    (w_data[k+1]),
            .o_tag     (w_tag[k+1])
        );
    end

    assign out_valid = w_vld[SHW];
    assign out_data  = w_data[SHW];
    assign out_tag   = w_tag[SHW];

    // Control fields of the final stage have no consumer.
    assign w_unused_tail = ^{w_op[SHW], w_shamt[SHW], w_sign[SHW]};

endmodule

// File: tb/tb_alu_shift_pipe.sv
module tb_alu_shift_pipe;
    import alu_shift_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [4:0]  in_shamt;
    logic [31:0] in_data;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_tag;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  tag;
        int          due;   // expected cycle of appearance, -1 = not timed
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    alu_shift_pipe #(.WIDTH(32), .TAG_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_shamt  (in_shamt),
        .in_data   (in_data),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: a result is consumed when out_valid & out_ready; compare to the scoreboard head.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            exp_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result got data=%h tag=%h with nothing outstanding", out_data, out_tag);
            end else begin
                e = exp_q.pop_front();
                if (out_data !== e.data || out_tag !== e.tag) begin
                    errors++;
                    $display("FAIL result got data=%h tag=%h want data=%h tag=%h", out_data, out_tag, e.data, e.tag);
                end
                if (e.due >= 0) begin
                    checks++;
                    if (cyc != e.due) begin
                        errors++;
                        $display("FAIL latency tag=%h got cycle %0d want cycle %0d", e.tag, cyc, e.due);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [2:0] op, input logic [4:0] sh, input logic [31:0] d,
                        input logic [4:0] tag, input logic [31:0] exp, input bit timed);
        exp_t e;
        int   n = 0;
        in_valid = 1'b1;
        in_op    = op;
        in_shamt = sh;
        in_data  = d;
        in_tag   = tag;
        #1;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout tag=%h in_ready stuck at 0", tag);
        end else begin
            e.data = exp;
            e.tag  = tag;
            e.due  = timed ? cyc + 5 : -1;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout got %0d pending want 0", exp_q.size());
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_op     = '0;
        in_shamt  = '0;
        in_data   = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_out_data", out_data, 32'd0);
        chk("reset_out_tag", {27'd0, out_tag}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Directed single operations
        send(OP_SLL, 5'd31, 32'h0000_0001, 5'h1A, 32'h8000_0000, 1'b1);
        drain();
        send(OP_SRA, 5'd4,  32'h8000_0000, 5'h01, 32'hF800_0000, 1'b1);
        send(OP_SRL, 5'd4,  32'h8000_0000, 5'h02, 32'h0800_0000, 1'b1);
        send(OP_SRA, 5'd31, 32'h7FFF_FFFF, 5'h03, 32'h0000_0000, 1'b1);
        send(OP_ROR, 5'd1,  32'h0000_0001, 5'h04, 32'h8000_0000, 1'b1);
        send(OP_ROL, 5'd4,  32'h8000_0001, 5'h05, 32'h0000_0018, 1'b1);
        drain();

        // shamt = 0 is identity for every op code
        for (int op = 0; op < 8; op++)
            send(op[2:0], 5'd0, 32'hDEAD_BEEF, 5'(op + 8), 32'hDEAD_BEEF, 1'b1);
        drain();

        // Back-to-back mixed ops: timed expectations force consecutive, in-order results
        send(OP_SLL, 5'd8,  32'h0000_000F, 5'h11, 32'h0000_0F00, 1'b1);
        send(OP_SRL, 5'd28, 32'hF000_0000, 5'h12, 32'h0000_000F, 1'b1);
        send(OP_SRA, 5'd31, 32'h8000_0000, 5'h13, 32'hFFFF_FFFF, 1'b1);
        send(OP_ROL, 5'd8,  32'h1234_5678, 5'h14, 32'h3456_7812, 1'b1);
        send(OP_ROR, 5'd4,  32'h1234_5678, 5'h15, 32'h8123_4567, 1'b1);
        send(3'b010, 5'd2,  32'h0000_0003, 5'h16, 32'h0000_000C, 1'b1);
        send(OP_SRA, 5'd1,  32'h4000_0000, 5'h17, 32'h2000_0000, 1'b1);
        send(3'b111, 5'd16, 32'h0000_FFFF, 5'h18, 32'hFFFF_0000, 1'b1);
        drain();

        // Backpressure: fill all five stages, then hold the head for three cycles
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++)
            send(OP_SLL, 5'(k), 32'h0000_0001, 5'(16 + k), 32'h1 << k, 1'b0);
        for (int k = 0; k < 3; k++) begin
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            chk("stall_out_data", out_data, 32'h0000_0001);
            chk("stall_out_tag", {27'd0, out_tag}, 32'd16);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        drain();

        // Flush with three ops in flight; the op offered during flush is dropped
        send(OP_SLL, 5'd1, 32'h0000_000A, 5'h09, 32'h0000_0014, 1'b0);
        send(OP_SLL, 5'd2, 32'h0000_000A, 5'h0A, 32'h0000_0028, 1'b0);
        send(OP_SLL, 5'd3, 32'h0000_000A, 5'h0B, 32'h0000_0050, 1'b0);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_op    = OP_ROR;
        in_shamt = 5'd1;
        in_data  = 32'h0000_0001;
        in_tag   = 5'h1F;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        send(OP_SRL, 5'd8, 32'h0000_0100, 5'h07, 32'h0000_0001, 1'b1);
        drain();

        // Reset with a full, stalled pipe
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++)
            send(OP_ROL, 5'd4, 32'h0000_000F, 5'(k + 1), 32'h0000_00F0, 1'b0);
        chk("pre_reset_out_data", out_data, 32'h0000_00F0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        chk("midreset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midreset_out_data", out_data, 32'd0);
        chk("midreset_out_tag", {27'd0, out_tag}, 32'd0);
        out_ready = 1'b1;
        send(OP_SRA, 5'd8, 32'hFFFF_FF00, 5'h03, 32'hFFFF_FFFF, 1'b1);
        drain();

        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
